// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, request kind enum, CSR addresses, cause codes,
// mstatus bit positions and the two mstatus read-modify-write helpers.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    T_EPC    = 3'd1,
    T_CAUSE  = 3'd2,
    T_STATUS = 3'd3,
    T_VEC    = 3'd4,
    M_STATUS = 3'd5,
    M_EPC    = 3'd6,
    REDIR    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    KIND_ILLEGAL = 2'd0,
    KIND_ECALL   = 2'd1,
    KIND_MRET    = 2'd2,
    KIND_IRQ     = 2'd3
  } kind_e;

  localparam logic [11:0] CSR_NONE    = 12'h000;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EXT_IRQ = 32'h8000_000B;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;

  // Trap entry: stash MIE into MPIE, disable interrupts, previous mode = M.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
    logic [31:0] r;
    r                = s;
    r[MPIE_BIT]      = s[MIE_BIT];
    r[MIE_BIT]       = 1'b0;
    r[MPP_HI:MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and leave MPIE set.
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
    logic [31:0] r;
    r           = s;
    r[MIE_BIT]  = s[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Bundle between the trap sequencer and its core: requests, CSR port, PC control.
// Latency: n/a (wires only).
// Backpressure: none; the sequencer stalls the pipeline through the stall signal.
// master: the sequencer side (drives CSR port, stall, redirect, busy).
// slave:  the core/CSR-file side (drives requests, PCs, mstatus_mie, csr_rdata).
interface trap_sequencer_if;
  logic        ecall_req;
  logic        mret_req;
  logic        illegal_req;
  logic        ext_irq;
  logic        mstatus_mie;
  logic [31:0] pc_in;
  logic [31:0] pc_next;
  logic [31:0] csr_rdata;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_we;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    input  ecall_req, mret_req, illegal_req, ext_irq, mstatus_mie,
    input  pc_in, pc_next, csr_rdata,
    output csr_addr, csr_wdata, csr_we, stall, redirect_valid, redirect_pc, busy
  );

  modport slave (
    output ecall_req, mret_req, illegal_req, ext_irq, mstatus_mie,
    output pc_in, pc_next, csr_rdata,
    input  csr_addr, csr_wdata, csr_we, stall, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/trap_sequencer_prio_enc.sv
// Picks the winning trap/return request: illegal > ecall > mret > enabled irq.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; caller qualifies accept_o with its own idle condition.
// Ports: four request inputs plus mstatus_mie_i; accept_o, kind_o, cause_o out.
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic        illegal_req_i,
  input  logic        ecall_req_i,
  input  logic        mret_req_i,
  input  logic        ext_irq_i,
  input  logic        mstatus_mie_i,
  output logic        accept_o,
  output kind_e       kind_o,
  output logic [31:0] cause_o
);

  always_comb begin
    accept_o = 1'b0;
    kind_o   = KIND_ILLEGAL;
    cause_o  = '0;
    if (illegal_req_i) begin
      accept_o = 1'b1;
      kind_o   = KIND_ILLEGAL;
      cause_o  = CAUSE_ILLEGAL;
    end else if (ecall_req_i) begin
      accept_o = 1'b1;
      kind_o   = KIND_ECALL;
      cause_o  = CAUSE_ECALL;
    end else if (mret_req_i) begin
      // MRET carries no cause; cause_o stays 0.
      accept_o = 1'b1;
      kind_o   = KIND_MRET;
    end else if (ext_irq_i && mstatus_mie_i) begin
      accept_o = 1'b1;
      kind_o   = KIND_IRQ;
      cause_o  = CAUSE_EXT_IRQ;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Sequences machine-mode trap entry (mepc/mcause/mstatus/mtvec) and MRET via the CSR port.
// Latency: redirect pulse 5 cycles after trap acceptance, 3 cycles after MRET acceptance.
// Backpressure: stall held from the acceptance cycle until REDIR; new requests ignored while busy.
// Ports: clk, rst (async, active high); bus (trap_sequencer_if.master) carries
// requests, PCs, mstatus_mie, the CSR read/write port, stall, redirect and busy.
module trap_sequencer
  import trap_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  trap_sequencer_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] tgt_q, tgt_d;

  logic        prio_accept;
  kind_e       prio_kind;
  logic [31:0] prio_cause;
  logic        accept_now;

  trap_prio_enc u_prio (
    .illegal_req_i (bus.illegal_req),
    .ecall_req_i   (bus.ecall_req),
    .mret_req_i    (bus.mret_req),
    .ext_irq_i     (bus.ext_irq),
    .mstatus_mie_i (bus.mstatus_mie),
    .accept_o      (prio_accept),
    .kind_o        (prio_kind),
    .cause_o       (prio_cause)
  );

  // Requests only count while idle; anything raised mid-sequence is dropped.
  assign accept_now = (state_q == IDLE) && prio_accept;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      epc_q   <= '0;
      cause_q <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept_now) state_d = (prio_kind == KIND_MRET) ? M_STATUS : T_EPC;
      T_EPC:    state_d = T_CAUSE;
      T_CAUSE:  state_d = T_STATUS;
      T_STATUS: state_d = T_VEC;
      T_VEC:    state_d = REDIR;
      M_STATUS: state_d = M_EPC;
      M_EPC:    state_d = REDIR;
      REDIR:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath captures: epc/cause at acceptance, redirect target from CSR reads.
  always_comb begin
    epc_d   = epc_q;
    cause_d = cause_q;
    tgt_d   = tgt_q;
    if (accept_now && (prio_kind != KIND_MRET)) begin
      // Interrupts resume at the next instruction; sync traps re-point at the faulting one.
      epc_d   = (prio_kind == KIND_IRQ) ? bus.pc_next : bus.pc_in;
      cause_d = prio_cause;
    end
    if (state_q == T_VEC) tgt_d = {bus.csr_rdata[31:2], 2'b00};
    if (state_q == M_EPC) tgt_d = bus.csr_rdata;
  end

  // Outputs; everything is forced low while reset is asserted.
  always_comb begin
    bus.csr_addr       = CSR_NONE;
    bus.csr_wdata      = '0;
    bus.csr_we         = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.busy           = 1'b0;
    if (!rst) begin
      bus.busy  = (state_q != IDLE);
      bus.stall = (state_q == IDLE) ? accept_now : (state_q != REDIR);
      unique case (state_q)
        T_EPC: begin
          bus.csr_addr  = CSR_MEPC;
          bus.csr_wdata = epc_q;
          bus.csr_we    = 1'b1;
        end
        T_CAUSE: begin
          bus.csr_addr  = CSR_MCAUSE;
          bus.csr_wdata = cause_q;
          bus.csr_we    = 1'b1;
        end
        T_STATUS: begin
          bus.csr_addr  = CSR_MSTATUS;
          bus.csr_wdata = mstatus_on_trap(bus.csr_rdata);
          bus.csr_we    = 1'b1;
        end
        T_VEC: begin
          bus.csr_addr = CSR_MTVEC;
        end
        M_STATUS: begin
          bus.csr_addr  = CSR_MSTATUS;
          bus.csr_wdata = mstatus_on_mret(bus.csr_rdata);
          bus.csr_we    = 1'b1;
        end
        M_EPC: begin
          bus.csr_addr = CSR_MEPC;
        end
        REDIR: begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = tgt_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus randomized requests.
// Latency: n/a.
// Backpressure: n/a.
module tb_trap_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_sequencer_if bus ();

  trap_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Small CSR file living in the bench; rdata is combinational on csr_addr.
  logic [31:0] c_mstatus, c_mtvec, c_mepc, c_mcause;
  logic        ld = 1'b0;
  logic [31:0] l_mstatus, l_mtvec, l_mepc, l_mcause;
  int          rv_cnt = 0;

  always_comb begin
    case (bus.csr_addr)
      12'h300: bus.csr_rdata = c_mstatus;
      12'h305: bus.csr_rdata = c_mtvec;
      12'h341: bus.csr_rdata = c_mepc;
      12'h342: bus.csr_rdata = c_mcause;
      default: bus.csr_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (ld) begin
      c_mstatus <= l_mstatus;
      c_mtvec   <= l_mtvec;
      c_mepc    <= l_mepc;
      c_mcause  <= l_mcause;
    end else if (bus.csr_we) begin
      case (bus.csr_addr)
        12'h300: c_mstatus <= bus.csr_wdata;
        12'h305: c_mtvec   <= bus.csr_wdata;
        12'h341: c_mepc    <= bus.csr_wdata;
        12'h342: c_mcause  <= bus.csr_wdata;
        default: ;
      endcase
    end
    if (bus.redirect_valid) rv_cnt <= rv_cnt + 1;
  end

  // Architectural reference state.
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    bus.illegal_req = 1'b0;
    bus.ecall_req   = 1'b0;
    bus.mret_req    = 1'b0;
    bus.ext_irq     = 1'b0;
  endtask

  // Entered and left at posedge+1.
  task automatic preload(input logic [31:0] ms, tv, ep, mc);
    l_mstatus = ms; l_mtvec = tv; l_mepc = ep; l_mcause = mc;
    m_mstatus = ms; m_mtvec = tv; m_mepc = ep; m_mcause = mc;
    ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  // Presents one request pattern and follows the resulting sequence cycle by cycle.
  // keep=1 leaves the requests asserted throughout (the next call checks re-acceptance).
  task automatic seq(input bit ill, ec, mr, irq, mie, input logic [31:0] pci, pcn,
                     input bit keep, input string tag);
    bit          acc, is_trap;
    int          len;
    logic [31:0] tgt;
    bus.illegal_req = ill; bus.ecall_req = ec; bus.mret_req = mr; bus.ext_irq = irq;
    bus.mstatus_mie = mie; bus.pc_in = pci; bus.pc_next = pcn;

    acc     = ill | ec | mr | (irq & mie);
    is_trap = ill | ec | (!mr & irq & mie);
    len     = 0;
    tgt     = 32'h0;
    if (is_trap) begin
      m_mepc   = (ill | ec) ? pci : pcn;
      m_mcause = ill ? 32'd2 : (ec ? 32'd11 : 32'h8000_000B);
      m_mstatus = (m_mstatus & ~32'h0000_1888) | 32'h0000_1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      tgt = m_mtvec & ~32'h3;
      len = 5;
    end else if (acc) begin
      tgt = m_mepc;
      m_mstatus = (m_mstatus & ~32'h0000_0088) | 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
      len = 3;
    end

    #1;
    chk1({tag, " accept stall"}, bus.stall, acc);
    chk1({tag, " accept busy"}, bus.busy, 1'b0);
    chk1({tag, " accept we"}, bus.csr_we, 1'b0);
    if (!acc) begin
      @(posedge clk);
      #1;
      chk1({tag, " ignored busy"}, bus.busy, 1'b0);
      chk1({tag, " ignored stall"}, bus.stall, 1'b0);
      clear_reqs();
      return;
    end

    for (int k = 1; k <= len; k++) begin
      @(posedge clk);
      #1;
      if (!keep) clear_reqs();
      #1;
      chk1($sformatf("%s c%0d stall", tag, k), bus.stall, (k < len));
      chk1($sformatf("%s c%0d busy", tag, k), bus.busy, 1'b1);
      chk1($sformatf("%s c%0d redirect_valid", tag, k), bus.redirect_valid, (k == len));
      chk($sformatf("%s c%0d redirect_pc", tag, k), bus.redirect_pc, (k == len) ? tgt : 32'h0);
    end
    @(posedge clk);
    #1;
    chk({tag, " mepc"}, c_mepc, m_mepc);
    chk({tag, " mcause"}, c_mcause, m_mcause);
    chk({tag, " mstatus"}, c_mstatus, m_mstatus);
    if (!keep) begin
      chk1({tag, " end busy"}, bus.busy, 1'b0);
      chk1({tag, " end stall"}, bus.stall, 1'b0);
      chk1({tag, " end redirect_valid"}, bus.redirect_valid, 1'b0);
    end
  endtask

  initial begin
    int rv0;
    rst = 1'b1;
    clear_reqs();
    bus.mstatus_mie = 1'b0;
    bus.pc_in = 32'h0;
    bus.pc_next = 32'h0;

    // Outputs must stay quiet under reset even with a request present.
    bus.ecall_req = 1'b1;
    bus.pc_in = 32'h0000_0abc;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst stall", bus.stall, 1'b0);
    chk1("rst busy", bus.busy, 1'b0);
    chk1("rst csr_we", bus.csr_we, 1'b0);
    chk("rst csr_addr", {20'h0, bus.csr_addr}, 32'h0);
    chk("rst csr_wdata", bus.csr_wdata, 32'h0);
    chk1("rst redirect_valid", bus.redirect_valid, 1'b0);
    chk("rst redirect_pc", bus.redirect_pc, 32'h0);
    clear_reqs();
    rst = 1'b0;
    #1;
    chk1("idle busy", bus.busy, 1'b0);
    chk("idle csr_addr", {20'h0, bus.csr_addr}, 32'h0);
    chk("idle csr_wdata", bus.csr_wdata, 32'h0);
    @(posedge clk);
    #1;

    // Scenario 1: ECALL.
    preload(32'h8, 32'h200, 32'h0, 32'h0);
    seq(0, 1, 0, 0, 0, 32'h100, 32'h104, 0, "s1");
    chk("s1 mstatus const", c_mstatus, 32'h1880);
    chk("s1 mcause const", c_mcause, 32'd11);

    // Scenario 2: interrupt taken, then masked.
    preload(32'h8, 32'h300, 32'h0, 32'h0);
    seq(0, 0, 0, 1, 1, 32'h40, 32'h44, 0, "s2a");
    chk("s2a mepc const", c_mepc, 32'h44);
    seq(0, 0, 0, 1, 0, 32'h40, 32'h44, 0, "s2b");

    // Scenario 3: illegal beats ECALL; exactly one redirect.
    preload(32'h8, 32'h1000_0003, 32'h0, 32'h0);
    rv0 = rv_cnt;
    seq(1, 1, 0, 0, 0, 32'h80, 32'h84, 0, "s3");
    @(posedge clk);
    #1;
    chk1("s3 stays idle", bus.busy, 1'b0);
    chk("s3 one redirect", rv_cnt - rv0, 32'd1);

    // Scenario 4: MRET.
    preload(32'h1880, 32'h200, 32'h104, 32'h0);
    seq(0, 0, 1, 0, 0, 32'h0, 32'h0, 0, "s4");
    chk("s4 mstatus const", c_mstatus, 32'h1888);

    // Scenario 5: reset while in T_CAUSE.
    preload(32'h8, 32'h200, 32'h0, 32'hdead_beef);
    rv0 = rv_cnt;
    bus.ecall_req = 1'b1;
    bus.pc_in = 32'h300;
    @(posedge clk);
    #1 clear_reqs();
    @(posedge clk);
    #1;
    chk("s5 in T_CAUSE", {20'h0, bus.csr_addr}, 32'h342);
    rst = 1'b1;
    #1;
    chk1("s5 busy at reset", bus.busy, 1'b0);
    chk1("s5 we at reset", bus.csr_we, 1'b0);
    chk1("s5 stall at reset", bus.stall, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("s5 mcause untouched", c_mcause, 32'hdead_beef);
    chk("s5 mepc", c_mepc, 32'h300);
    chk("s5 mstatus untouched", c_mstatus, 32'h8);
    chk("s5 no redirect", rv_cnt - rv0, 32'd0);
    chk1("s5 idle after", bus.busy, 1'b0);
    m_mepc = 32'h300;

    // Scenario 6: ECALL held across two back-to-back sequences.
    preload(32'h8, 32'h240, 32'h0, 32'h0);
    seq(0, 1, 0, 0, 0, 32'h500, 32'h504, 1, "s6a");
    seq(0, 1, 0, 0, 0, 32'h500, 32'h504, 0, "s6b");

    // Randomized request mixes against the reference model.
    for (int i = 0; i < 40; i++) begin
      preload($urandom, $urandom, $urandom, $urandom);
      seq(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
          $urandom, $urandom, 0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (in, 1, rising-edge clock) and rst (in, 1, async active-high reset).
REQ-002 ecall_req  in  1  ECALL decoded in the current instruction slot.
REQ-003 mret_req  in  1  MRET decoded in the current instruction slot.
REQ-004 illegal_req  in  1  illegal opcode decoded in the current instruction slot.
REQ-005 ext_irq  in  1  level-sensitive external interrupt.
REQ-006 mstatus_mie  in  1  current mstatus.MIE from the CSR file.
REQ-007 pc_in  in  32  PC of the current instruction.
REQ-008 pc_next  in  32  PC of the next sequential instruction.
REQ-009 csr_rdata  in  32  combinational CSR read data for csr_addr.
REQ-010 csr_addr  out  12  CSR index, used for both read and write.
REQ-011 csr_wdata  out  32  CSR write data.
REQ-012 csr_we  out  1  CSR write enable.
REQ-013 stall  out  1  freezes PC and pipeline registers.
REQ-014 redirect_valid  out  1  one-cycle pulse that loads redirect_pc into the PC.
REQ-015 redirect_pc  out  32  trap or return target.
REQ-016 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 States SHALL be: IDLE, T_EPC, T_CAUSE, T_STATUS, T_VEC, M_STATUS, M_EPC, REDIR.
REQ-018 Acceptance in IDLE SHALL follow this priority: illegal_req > ecall_req > mret_req > (ext_irq & mstatus_mie).
REQ-019 On acceptance, in the same cycle, the block SHALL latch:
- epc_q = pc_in for synchronous traps, or pc_next for an interrupt;
- cause_q = 32'd2 (illegal), 32'd11 (ECALL) or 32'h8000_000B (interrupt).
REQ-020 Trap path: IDLE -> T_EPC -> T_CAUSE -> T_STATUS -> T_VEC -> REDIR -> IDLE, one cycle per state.
REQ-021 MRET path: IDLE -> M_STATUS -> M_EPC -> REDIR -> IDLE.
REQ-022 T_EPC SHALL drive csr_addr=0x341, csr_wdata=epc_q, csr_we=1.
REQ-023 T_CAUSE SHALL drive csr_addr=0x342, csr_wdata=cause_q, csr_we=1.
REQ-024 T_STATUS SHALL perform a read-modify-write of 0x300 in one cycle: MPIE(bit7) <= MIE(bit3), MIE <= 0, MPP(bits 12:11) <= 2'b11, all other bits unchanged.
REQ-025 T_VEC SHALL drive csr_addr=0x305, csr_we=0, and latch tgt_q = {csr_rdata[31:2], 2'b00} (direct mode only).
REQ-026 M_STATUS SHALL perform a read-modify-write of 0x300: MIE <= MPIE, MPIE <= 1, all other bits unchanged.
REQ-027 M_EPC SHALL read 0x341 with csr_we=0 and latch tgt_q = csr_rdata.
REQ-028 REDIR SHALL drive redirect_valid=1 and redirect_pc=tgt_q for exactly one cycle; redirect_pc SHALL be 0 in all other cycles.
REQ-029 stall SHALL be high combinationally in the acceptance cycle and in every non-IDLE state except REDIR.
REQ-030 In IDLE with no acceptance: csr_we=0, csr_addr=0, csr_wdata=0.
REQ-031 All requests SHALL be ignored while busy; an ext_irq still asserted on return to IDLE SHALL be re-evaluated against the then-current mstatus_mie.
REQ-032 Trap latency SHALL be 5 cycles from acceptance to the redirect_valid pulse; MRET latency SHALL be 3 cycles.

Reset
REQ-033 rst SHALL asynchronously force state=IDLE and epc_q, cause_q, tgt_q = 0; all outputs SHALL be 0 while rst is high.
REQ-034 Reset mid-sequence SHALL abandon the sequence: no further CSR writes and no redirect pulse.

Structure
REQ-035 Package trap_pkg SHALL hold the state enum, the CSR address constants (0x300, 0x305, 0x341, 0x342), the cause constants and the MIE/MPIE/MPP bit positions.
REQ-036 Request priority encoding SHALL be a sub-module trap_prio_enc, a combinational block taking the four requests plus mstatus_mie and producing accept, kind and cause.

Verification
REQ-037 Scenario 1: ecall_req with pc_in=0x100, mtvec=0x200, mstatus=0x8 -> mepc=0x100, mcause=11, mstatus=0x1880, redirect_pc=0x200 five cycles after acceptance.
REQ-038 Scenario 2: ext_irq=1, mstatus_mie=1, pc_next=0x44 -> mepc=0x44, mcause=0x8000000B; with mstatus_mie=0 the block SHALL stay in IDLE and stall=0.
REQ-039 Scenario 3: illegal_req and ecall_req in the same cycle -> mcause=2 and exactly one trap sequence.
REQ-040 Scenario 4: mret_req with mepc=0x104, mstatus=0x1880 -> mstatus=0x1888, redirect_pc=0x104 three cycles after acceptance.
REQ-041 Scenario 5: rst asserted during T_CAUSE -> mcause unwritten, no redirect_valid pulse, busy=0 immediately.
REQ-042 Scenario 6: ecall_req held high across a full sequence -> a second sequence starts only from IDLE, and stall is low exactly in the REDIR cycle.
